// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/host memory arbiter.
// Owner tag encoding and default geometry.
package mem_arbiter_pkg;

  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   rd;
    owner_e own;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the CPU input can be masked.
// Ties go to whichever input did not win last.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_cpu,
  input  logic i_req_host,
  input  logic i_mask_cpu,
  output logic o_gnt_cpu,
  output logic o_gnt_host
);

  owner_e r_last;
  logic   w_cpu;

  assign w_cpu = i_req_cpu & ~i_mask_cpu;

  always_comb begin
    o_gnt_host = i_req_host
               & (~w_cpu | (r_last == OWNER_CPU));
    o_gnt_cpu  = w_cpu
               & (~i_req_host | (r_last == OWNER_HOST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWNER_CPU;
    end else if (o_gnt_cpu) begin
      r_last <= OWNER_CPU;
    end else if (o_gnt_host) begin
      r_last <= OWNER_HOST;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and the host port.
// Registered command, 2-cycle tagged read return, stall counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_stall,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdata,
  input  logic             host_hold,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  logic          w_gnt;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  tag_t          r_t1;
  tag_t          r_t2;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_host_rdata;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_cpu  (cpu_req),
    .i_req_host (host_req),
    .i_mask_cpu (host_hold),
    .o_gnt_cpu  (cpu_gnt),
    .o_gnt_host (host_gnt)
  );

  assign w_gnt     = cpu_gnt | host_gnt;
  assign w_we      = host_gnt ? host_we    : cpu_we;
  assign w_addr    = host_gnt ? host_addr  : cpu_addr;
  assign w_wdata   = host_gnt ? host_wdata : cpu_wdata;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= w_gnt;
      mem_we <= w_gnt & w_we;
      if (w_gnt) begin
        mem_addr  <= w_addr;
        mem_wdata <= w_wdata;
      end
    end
  end

  // Tag follows the command; stage 2 lines up with mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= '0;
      r_t2 <= '0;
    end else begin
      r_t1.rd  <= w_gnt & ~w_we;
      r_t1.own <= host_gnt ? OWNER_HOST : OWNER_CPU;
      r_t2     <= r_t1;
    end
  end

  assign cpu_rvalid  = r_t2.rd & (r_t2.own == OWNER_CPU);
  assign host_rvalid = r_t2.rd & (r_t2.own == OWNER_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : r_cpu_rdata;
  assign host_rdata  = host_rvalid ? mem_rdata : r_host_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (cpu_rvalid)  r_cpu_rdata  <= mem_rdata;
      if (host_rvalid) r_host_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (cpu_stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences,
// a grant table and random traffic against a reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic host_req, host_we, host_gnt, host_rvalid, host_hold;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [CW-1:0] stall_cnt;
  logic stall_clr, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_hold(host_hold),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory macro with a preload port.
  logic [DW-1:0] mem [256];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, last winner, outstanding reads.
  logic [DW-1:0] mm [256];
  bit            m_lw, m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_crd, m_hrd;
  int            m_cnt;
  bit            g_c, g_h;
  typedef struct { bit own; logic [DW-1:0] d; } ret_t;
  ret_t          rq[$];
  bit            slot[$];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_lw = 0; m_en = 0; m_we = 0; m_addr = '0; m_wd = '0;
    m_crd = '0; m_hrd = '0; m_cnt = 0; g_c = 0; g_h = 0;
    rq.delete(); slot = '{0, 0};
  endtask

  task automatic chk_zero();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_gnts", {cpu_gnt, host_gnt}, 0);
  endtask

  // One clock: compare every output with the model, then advance it.
  task automatic cycle();
    bit cr, ec, eh, we, rv, has;
    ret_t r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #2;
    cr = cpu_req && !host_hold;
    eh = host_req && (!cr || !m_lw);
    ec = cr && !eh;
    has = slot[0];
    if (has) r = rq[0];
    chk("cpu_gnt", cpu_gnt, ec);
    chk("host_gnt", host_gnt, eh);
    chk("cpu_stall", cpu_stall, cpu_req && !ec);
    chk("mem_en", mem_en, m_en);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wd);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("cpu_rvalid", cpu_rvalid, has && !r.own);
    chk("host_rvalid", host_rvalid, has && r.own);
    chk("cpu_rdata", cpu_rdata, (has && !r.own) ? r.d : m_crd);
    chk("host_rdata", host_rdata, (has && r.own) ? r.d : m_hrd);
    if (has) begin
      void'(rq.pop_front());
      if (r.own) m_hrd = r.d; else m_crd = r.d;
    end
    void'(slot.pop_front());
    g_c = ec; g_h = eh;
    we = eh ? host_we : cpu_we;
    a  = eh ? host_addr : cpu_addr;
    d  = eh ? host_wdata : cpu_wdata;
    rv = 0;
    if (ec || eh) begin
      if (we) mm[a] = d;
      else begin rv = 1; rq.push_back('{eh, mm[a]}); end
      m_lw = eh; m_en = 1; m_we = we; m_addr = a; m_wd = d;
    end else begin
      m_en = 0; m_we = 0;
    end
    slot.push_back(rv);
    if (stall_clr) m_cnt = 0;
    else if (cpu_req && !ec && m_cnt < CMAX) m_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic set_cpu(bit r, bit w, logic [AW-1:0] a,
                         logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(bit r, bit w, logic [AW-1:0] a,
                          logic [DW-1:0] d);
    host_req = r; host_we = w; host_addr = a; host_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 0; #1;
    chk_zero();
    model_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit c, h, hold, ec, eh;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 1, 0, 0, 1};
    tbl[1] = '{1, 1, 0, 1, 0};
    tbl[2] = '{1, 0, 0, 1, 0};
    tbl[3] = '{1, 1, 0, 0, 1};
    tbl[4] = '{0, 1, 0, 0, 1};
    tbl[5] = '{1, 1, 0, 1, 0};
    tbl[6] = '{1, 1, 1, 0, 1};
    tbl[7] = '{1, 0, 1, 0, 0};
    tbl[8] = '{1, 1, 0, 1, 0};
    tbl[9] = '{0, 0, 0, 0, 0};

    set_cpu(0, 0, 0, 0); set_host(0, 0, 0, 0);
    host_hold = 0; stall_clr = 0; pl_en = 0; pl_a = 0; pl_d = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      pl_en = 1; pl_a = AW'(i);
      pl_d = (i == 5) ? 16'h0A12 : DW'($urandom);
      mm[i] = pl_d;
      @(posedge clk); #1;
    end
    pl_en = 0;
    chk_zero();
    rst_n = 1;
    @(posedge clk); #1;

    // Single CPU read of 0x05.
    set_cpu(1, 0, 8'h05, 0);
    cycle();
    set_cpu(0, 0, 8'h05, 0);
    #1 chk("rd1_mem_addr", {mem_en, mem_addr}, 9'h105);
    cycle();
    #1 chk("rd1_rvalid", {cpu_rvalid, host_rvalid}, 2'b10);
    chk("rd1_rdata", cpu_rdata, 16'h0A12);
    cycle();

    // Both held for six cycles, CPU won last.
    set_cpu(1, 0, 8'h01, 0); set_host(1, 0, 8'h02, 0);
    for (int i = 0; i < 6; i++) begin
      #1 chk("alt_host_gnt", host_gnt, (i % 2) == 0);
      cycle();
    end
    set_cpu(0, 0, 0, 0); set_host(0, 0, 0, 0);
    #1 chk("alt_stall3", stall_cnt, 3);
    cycle(); cycle();

    // Host program load under hold.
    stall_clr = 1; cycle(); stall_clr = 0;
    host_hold = 1;
    set_cpu(1, 0, 8'h07, 0);
    for (int i = 0; i < 4; i++) begin
      set_host(1, 1, AW'(i), DW'(i + 1));
      cycle();
    end
    host_hold = 0; set_host(0, 0, 0, 0);
    #1 chk("hold_stall4", stall_cnt, 4);
    chk("hold_release_gnt", cpu_gnt, 1);
    cycle();
    set_cpu(0, 0, 0, 0);
    cycle(); cycle();

    // Reset between a CPU read grant and its return.
    set_cpu(1, 0, 8'h09, 0);
    cycle();
    set_cpu(0, 0, 0, 0);
    do_reset();
    #1 chk("rst_drop_rvalid", cpu_rvalid, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Stall counter saturation and clear priority.
    host_hold = 1; set_cpu(1, 0, 8'h03, 0);
    for (int i = 0; i < 20; i++) cycle();
    #1 chk("sat_cnt", stall_cnt, CMAX);
    stall_clr = 1; cycle(); stall_clr = 0;
    #1 chk("clr_prio", stall_cnt, 0);
    host_hold = 0; set_cpu(0, 0, 0, 0);
    cycle(); cycle(); cycle();

    // Host write then back-to-back CPU read of the same address.
    set_host(1, 1, 8'h10, 16'hBEEF);
    cycle();
    set_host(0, 0, 0, 0); set_cpu(1, 0, 8'h10, 0);
    cycle();
    set_cpu(0, 0, 0, 0);
    cycle();
    #1 chk("raw_rvalid", cpu_rvalid, 1);
    chk("raw_rdata", cpu_rdata, 16'hBEEF);
    cycle();

    // Grant table from a fresh reset.
    do_reset();
    foreach (tbl[i]) begin
      set_cpu(tbl[i].c, 0, AW'($urandom), 0);
      set_host(tbl[i].h, 0, AW'($urandom), 0);
      host_hold = tbl[i].hold;
      #1 chk("tbl_gnt", {cpu_gnt, host_gnt}, {tbl[i].ec, tbl[i].eh});
      cycle();
    end
    host_hold = 0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if (!cpu_req || g_c)
        set_cpu($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                AW'($urandom), DW'($urandom));
      else if ($urandom_range(0, 7) == 0) cpu_req = 0;
      if (!host_req || g_h)
        set_host($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 15)), DW'($urandom));
      else if ($urandom_range(0, 7) == 0) host_req = 0;
      if ($urandom_range(0, 15) == 0) host_hold = ~host_hold;
      stall_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end
    set_cpu(0, 0, 0, 0); set_host(0, 0, 0, 0);
    host_hold = 0; stall_clr = 0;
    for (int i = 0; i < 4; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
